// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Turns single-cycle data-memory strobes from the control unit into req/ack
//   transactions on the data-memory port. It also owns the memory address
//   register (MAR) and the image row/column counters, and returns read data
//   to the datapath.
//
//   Transaction flow:
//     IDLE   --dmem_write--> WR_REQ   (write wins if read and write collide)
//     IDLE   --dmem_read --> RD_REQ
//     xx_REQ --mem_ack   --> IDLE
//   Address, write data and direction are captured on the strobe edge and
//   held unchanged for the whole request. Strobes that arrive while a
//   transaction is outstanding are dropped and flagged in err_overrun.
module dmem_access_unit #(
    parameter  int DATA_W   = 16,
    parameter  int ADDR_W   = 16,
    parameter  int IMG_COLS = 256,
    parameter  int IMG_ROWS = 256,
    localparam int ROW_W    = $clog2(IMG_ROWS),
    localparam int COL_W    = $clog2(IMG_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    // Strobes from the control unit
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic              mar_inc,
    input  logic              col_inc,
    input  logic              row_inc,
    input  logic              col_zero,
    input  logic              addr_sel,
    input  logic [DATA_W-1:0] wdata,
    // Data-memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    // Datapath side
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] mar,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              frame_done,
    output logic              err_overrun
);

    // Transaction FSM encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_REQ = 2'd1;
    localparam logic [1:0] WR_REQ = 2'd2;

    // Last legal counter values, used for the wrap decisions
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q,    err_d;

    logic [ADDR_W-1:0] mar_q,    mar_d;
    logic [ROW_W-1:0]  row_q,    row_d;
    logic [COL_W-1:0]  col_q,    col_d;
    logic              frame_q,  frame_d;

    // Helper nets
    logic [ADDR_W-1:0] lin_addr;
    logic [ADDR_W-1:0] strobe_addr;
    logic              col_wrap;
    logic              row_step;
    logic              row_wrap;
    logic              strobe_any;

    // Image address row*IMG_COLS+col; modular arithmetic in ADDR_W gives the truncation for free
    always_comb begin
        lin_addr = ADDR_W'(row_q) * ADDR_W'(IMG_COLS) + ADDR_W'(col_q);
    end

    // Address captured on a strobe always uses the counters as they were before this edge
    always_comb begin
        strobe_addr = addr_sel ? lin_addr : mar_q;
        strobe_any  = dmem_read | dmem_write;
    end

    // Next-state logic for the transaction FSM, latched request fields, read data and error flag
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (dmem_write) begin
                    // Write wins a read/write collision; the read is lost and flagged.
                    state_d = WR_REQ;
                    we_d    = 1'b1;
                    addr_d  = strobe_addr;
                    wdata_d = wdata;
                    if (dmem_read) begin
                        err_d = 1'b1;
                    end
                end else if (dmem_read) begin
                    state_d = RD_REQ;
                    we_d    = 1'b0;
                    addr_d  = strobe_addr;
                    wdata_d = wdata;
                end
            end

            RD_REQ: begin
                // Any new strobe while a read is outstanding is dropped.
                if (strobe_any) begin
                    err_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d  = IDLE;
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                end
            end

            WR_REQ: begin
                if (strobe_any) begin
                    err_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next-state logic for MAR and the image row/column counters
    always_comb begin
        mar_d    = mar_q;
        col_d    = col_q;
        row_d    = row_q;
        frame_d  = 1'b0;

        // col_zero overrides col_inc, so a suppressed col_inc never carries into row.
        col_wrap = col_inc && !col_zero && (col_q == COL_LAST);
        // An explicit row_inc and a column carry in the same cycle are a single +1.
        row_step = row_inc || col_wrap;
        row_wrap = row_step && (row_q == ROW_LAST);

        if (mar_inc) begin
            mar_d = mar_q + 1'b1;
        end

        if (col_zero || col_wrap) begin
            col_d = '0;
        end else if (col_inc) begin
            col_d = col_q + 1'b1;
        end

        if (row_wrap) begin
            row_d   = '0;
            frame_d = 1'b1;
        end else if (row_step) begin
            row_d = row_q + 1'b1;
        end
    end

    // Transaction registers; reset abandons any outstanding request and clears read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Counter registers; they advance regardless of any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            mar_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            mar_q   <= mar_d;
            row_q   <= row_d;
            col_q   <= col_d;
            frame_q <= frame_d;
        end
    end

    // All outputs come straight from registers
    always_comb begin
        mem_req     = (state_q != IDLE);
        busy        = (state_q != IDLE);
        mem_we      = we_q;
        mem_addr    = addr_q;
        mem_wdata   = wdata_q;
        rdata       = rdata_q;
        rdata_valid = rvalid_q;
        err_overrun = err_q;
        mar         = mar_q;
        row         = row_q;
        col         = col_q;
        frame_done  = frame_q;
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit
//   Directed stimulus for dmem_access_unit with a 4x4 image. Expected memory
//   transactions and read returns are queued when stimulus is issued; a
//   separate monitor pops and compares whenever the DUT raises mem_req or
//   rdata_valid.
module tb_dmem_access_unit;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int IMG_COLS = 4;
    localparam int IMG_ROWS = 4;

    logic              clk;
    logic              reset;
    logic              dmem_read, dmem_write, mar_inc, col_inc, row_inc, col_zero, addr_sel;
    logic [DATA_W-1:0] wdata;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid, busy;
    logic [ADDR_W-1:0] mar;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              frame_done, err_overrun;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          len;   // expected mem_req cycles; 0 = do not check
    } txn_t;

    txn_t        txq[$];
    logic [15:0] rdq[$];

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;
    int fd_exp   = 0;

    dmem_access_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .IMG_COLS(IMG_COLS),
        .IMG_ROWS(IMG_ROWS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .mar_inc    (mar_inc),
        .col_inc    (col_inc),
        .row_inc    (row_inc),
        .col_zero   (col_zero),
        .addr_sel   (addr_sel),
        .wdata      (wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .busy       (busy),
        .mar        (mar),
        .row        (row),
        .col        (col),
        .frame_done (frame_done),
        .err_overrun(err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mar_inc    = 1'b0;
        col_inc    = 1'b0;
        row_inc    = 1'b0;
        col_zero   = 1'b0;
        addr_sel   = 1'b0;
    endtask

    // One-cycle pulse of any combination of counter strobes
    task automatic pulse(input bit mi, input bit ci, input bit ri, input bit cz);
        mar_inc  = mi;
        col_inc  = ci;
        row_inc  = ri;
        col_zero = cz;
        step();
        clear_strobes();
    endtask

    // Full transaction: strobe, wait cycles, ack. Expectations are queued first.
    task automatic xfer(input bit rd_s, input bit wr_s, input logic [15:0] wd,
                        input logic [15:0] exp_addr, input int waits, input logic [15:0] rdv);
        txn_t t;
        t.we    = wr_s;
        t.addr  = exp_addr;
        t.wdata = wd;
        t.len   = waits + 1;
        txq.push_back(t);
        if (!wr_s) rdq.push_back(rdv);
        dmem_read  = rd_s;
        dmem_write = wr_s;
        wdata      = wd;
        step();
        clear_strobes();
        repeat (waits) step();
        mem_rdata = rdv;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Monitor: compares every request cycle and every read return against the queues
    initial begin : monitor
        txn_t        cur;
        int          cur_len;
        logic        req_prev;
        logic [15:0] exp_rd;
        cur      = '{we: 1'b0, addr: 16'h0, wdata: 16'h0, len: 0};
        cur_len  = 0;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!req_prev) begin
                    cur_len = 0;
                    if (txq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL txn_unexpected: got we=%b addr=%0h, required no transaction",
                                 mem_we, mem_addr);
                        cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, len: 0};
                    end else begin
                        cur = txq.pop_front();
                    end
                end
                cur_len++;
                if (cur.we)
                    check("txn_write", 64'({mem_we, mem_addr, mem_wdata}), 64'({1'b1, cur.addr, cur.wdata}));
                else
                    check("txn_read", 64'({mem_we, mem_addr}), 64'({1'b0, cur.addr}));
            end else if (req_prev && cur.len != 0) begin
                check("req_len", 64'(cur_len), 64'(cur.len));
            end
            req_prev = (mem_req === 1'b1);

            if (rdata_valid === 1'b1) begin
                if (rdq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected: got rdata_valid=1 rdata=%0h, required none", rdata);
                end else begin
                    exp_rd = rdq.pop_front();
                    check("rdata", 64'(rdata), 64'(exp_rd));
                end
            end
            if (frame_done === 1'b1) fd_count++;
        end
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        txn_t t;
        reset     = 1'b1;
        clear_strobes();
        wdata     = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        step();
        step();
        check("reset_port", 64'({mem_req, mem_we, mem_addr, mem_wdata, rdata, rdata_valid, busy}), 64'(0));
        check("reset_cnt", 64'({mar, row, col, frame_done, err_overrun}), 64'(0));
        reset = 1'b0;
        step();

        // 1: write A5A5 at MAR=0, two wait cycles
        xfer(1'b0, 1'b1, 16'hA5A5, 16'h0000, 2, 16'h0000);
        check("t1_busy", 64'(busy), 64'(0));

        // 2: MAR to 5, zero-wait read
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_mar", 64'(mar), 64'(5));
        xfer(1'b1, 1'b0, 16'h0000, 16'h0005, 0, 16'h1234);
        check("t2_busy", 64'(busy), 64'(0));
        check("t2_rdata", 64'(rdata), 64'(16'h1234));
        step();
        check("t2_rvalid_off", 64'(rdata_valid), 64'(0));

        // 3: column counting and image addressing
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_col3", 64'(col), 64'(3));
        col_inc  = 1'b1;
        addr_sel = 1'b1;
        xfer(1'b1, 1'b0, 16'h0000, 16'h0003, 1, 16'h0BEE);
        check("t3_rowcol", 64'({row, col}), 64'({2'd1, 2'd0}));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        addr_sel = 1'b1;
        xfer(1'b0, 1'b1, 16'h5A5A, 16'h0005, 0, 16'h0000);   // row 1, col 1 -> 5
        pulse(1'b0, 1'b0, 1'b1, 1'b1);
        check("t3_rowinc_colzero", 64'({row, col}), 64'({2'd2, 2'd0}));

        // 4: row wrap and frame_done, col_zero priority, implicit carry
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_row3", 64'({row, frame_done}), 64'({2'd3, 1'b0}));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        fd_exp++;
        check("t4_wrap", 64'({row, frame_done}), 64'({2'd0, 1'b1}));
        step();
        check("t4_fd_pulse", 64'(frame_done), 64'(0));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_colzero_prio", 64'({row, col}), 64'({2'd0, 2'd0}));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);                        // row_inc + carry = one step
        check("t4_single_step", 64'({row, col}), 64'({2'd2, 2'd0}));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);                        // carry wraps the frame
        fd_exp++;
        check("t4_carry_wrap", 64'({row, col, frame_done}), 64'({2'd0, 2'd0, 1'b1}));

        // 5a: read+write collision in IDLE
        check("t5_err_clear", 64'(err_overrun), 64'(0));
        xfer(1'b1, 1'b1, 16'hC3C3, 16'h0005, 0, 16'h0000);
        check("t5_err_collide", 64'(err_overrun), 64'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_err_reset", 64'({err_overrun, mar}), 64'(0));

        // 5b: strobes while a read is pending are dropped
        t = '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000, len: 2};
        txq.push_back(t);
        rdq.push_back(16'h7777);
        dmem_read = 1'b1;
        step();
        clear_strobes();
        check("t5_pending", 64'({busy, err_overrun}), 64'({1'b1, 1'b0}));
        dmem_read  = 1'b1;
        dmem_write = 1'b1;
        wdata      = 16'hFFFF;
        step();
        clear_strobes();
        check("t5_err_busy", 64'(err_overrun), 64'(1));
        mem_rdata = 16'h7777;
        mem_ack   = 1'b1;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) step();
        check("t5_err_sticky", 64'({err_overrun, busy}), 64'({1'b1, 1'b0}));

        // 6: reset while mem_req is high, late ack ignored
        t = '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000, len: 0};
        txq.push_back(t);
        dmem_read = 1'b1;
        step();
        clear_strobes();
        check("t6_req", 64'(mem_req), 64'(1));
        reset = 1'b1;
        step();
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("t6_after", 64'({mem_req, busy, rdata, err_overrun}), 64'(0));
        repeat (3) step();
        check("t6_quiet", 64'({mem_req, rdata_valid, rdata}), 64'(0));

        // Everything queued must have been seen
        repeat (2) step();
        check("txq_empty", 64'(txq.size()), 64'(0));
        check("rdq_empty", 64'(rdq.size()), 64'(0));
        check("frame_count", 64'(fd_count), 64'(fd_exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
